// File: rtl/i2c_init_sequencer.sv
// Replays a ROM table of 3-byte I2C register writes through the i2cMaster Avalon-MM
// slave port, polling status between bytes and retrying entries that see a NACK.
module i2c_init_sequencer #(
   parameter int NUM_ENTRIES = 11,
   parameter int IDX_W       = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1,
   parameter int RETRIES     = 2,
   parameter int POLL_GAP    = 16
) (
   input  logic             clk,
   input  logic             resetN,
   input  logic             start,
   output logic             busy,
   output logic             done,
   output logic             err,
   output logic [IDX_W-1:0] errIdx,
   output logic [IDX_W-1:0] tblAdr,
   input  logic [23:0]      tblData,
   output logic [1:0]       avmAdr,
   output logic             avmWr,
   output logic [7:0]       avmWrData,
   output logic             avmRd,
   input  logic [7:0]       avmRdData
);

   typedef enum logic [3:0] {
      S_IDLE, S_FETCH, S_LOAD, S_WR_TX, S_WR_CMD, S_GAP, S_RD_ST, S_CHK,
      S_ABORT, S_ABORT_GAP, S_ABORT_RD, S_ABORT_CHK, S_NEXT, S_FIN
   } state_e;

   localparam logic [1:0]       ADR_TX     = 2'd0;
   localparam logic [1:0]       ADR_CMD    = 2'd1;
   localparam logic [1:0]       ADR_STATUS = 2'd2;
   localparam logic [7:0]       CMD_STOP   = 8'h02;
   localparam logic [9:0]       GAP_LOAD   = 10'(POLL_GAP - 1);
   localparam logic [2:0]       RETRY_MAX  = 3'(RETRIES);
   localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_ENTRIES - 1);

   state_e           state_q, state_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic [1:0]       byte_q, byte_d;
   logic [2:0]       retry_q, retry_d;
   logic [9:0]       gap_q, gap_d;
   logic [23:0]      entry_q, entry_d;
   logic             err_q, err_d;
   logic [IDX_W-1:0] err_idx_q, err_idx_d;

   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic [IDX_W-1:0] tbl_adr_q, tbl_adr_d;
   logic [1:0]       avm_adr_q, avm_adr_d;
   logic             avm_wr_q, avm_wr_d;
   logic [7:0]       avm_wr_data_q, avm_wr_data_d;
   logic             avm_rd_q, avm_rd_d;
   logic [7:0]       tx_byte;

   logic st_busy, st_nack;
   logic unused_rd_bits;
   assign st_busy        = avmRdData[0];
   assign st_nack        = avmRdData[1];
   assign unused_rd_bits = ^avmRdData[7:2];

   always_comb begin
      // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latch).
      state_d   = state_q;
      idx_d     = idx_q;
      byte_d    = byte_q;
      retry_d   = retry_q;
      entry_d   = entry_q;
      err_d     = err_q;
      err_idx_d = err_idx_q;
      gap_d     = GAP_LOAD;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d   = S_FETCH;
               idx_d     = '0;
               byte_d    = '0;
               retry_d   = '0;
               err_d     = 1'b0;
               err_idx_d = '0;
            end
         end
         S_FETCH:  state_d = S_LOAD;
         S_LOAD: begin
            entry_d = tblData;
            state_d = S_WR_TX;
         end
         S_WR_TX:  state_d = S_WR_CMD;
         S_WR_CMD: state_d = S_GAP;
         S_GAP: begin
            if (gap_q == '0) state_d = S_RD_ST;
            else             gap_d   = gap_q - 10'd1;
         end
         S_RD_ST:  state_d = S_CHK;
         S_CHK: begin
            if (st_busy)              state_d = S_GAP;
            else if (st_nack)         state_d = S_ABORT;
            else if (byte_q != 2'd2) begin
               byte_d  = byte_q + 2'd1;
               state_d = S_WR_TX;
            end else                  state_d = S_NEXT;
         end
         S_ABORT:  state_d = S_ABORT_GAP;
         S_ABORT_GAP: begin
            if (gap_q == '0) state_d = S_ABORT_RD;
            else             gap_d   = gap_q - 10'd1;
         end
         S_ABORT_RD: state_d = S_ABORT_CHK;
         S_ABORT_CHK: begin
            if (st_busy) state_d = S_ABORT_GAP;
            else if (retry_q < RETRY_MAX) begin
               retry_d = retry_q + 3'd1;
               byte_d  = '0;
               state_d = S_WR_TX;
            end else begin
               err_d     = 1'b1;
               err_idx_d = idx_q;
               state_d   = S_FIN;
            end
         end
         S_NEXT: begin
            if (idx_q == LAST_IDX) state_d = S_FIN;
            else begin
               idx_d   = idx_q + IDX_W'(1);
               retry_d = '0;
               byte_d  = '0;
               state_d = S_FETCH;
            end
         end
         S_FIN:    state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase

      case (byte_d)
         2'd0:    tx_byte = entry_d[23:16];
         2'd1:    tx_byte = entry_d[15:8];
         default: tx_byte = entry_d[7:0];
      endcase

      // Outputs are decoded from the next state so every port comes straight off a flop.
      busy_d        = !(state_d inside {S_IDLE, S_FIN});
      done_d        = (state_d == S_FIN);
      tbl_adr_d     = (state_d == S_FETCH) ? idx_d : tbl_adr_q;
      avm_wr_d      = state_d inside {S_WR_TX, S_WR_CMD, S_ABORT};
      avm_rd_d      = state_d inside {S_RD_ST, S_ABORT_RD};
      avm_adr_d     = avm_adr_q;
      avm_wr_data_d = avm_wr_data_q;
      case (state_d)
         S_WR_TX: begin
            avm_adr_d     = ADR_TX;
            avm_wr_data_d = tx_byte;
         end
         S_WR_CMD: begin
            avm_adr_d     = ADR_CMD;
            avm_wr_data_d = {5'b0, 1'b1, byte_d == 2'd2, byte_d == 2'd0};
         end
         S_ABORT: begin
            avm_adr_d     = ADR_CMD;
            avm_wr_data_d = CMD_STOP;
         end
         S_RD_ST, S_ABORT_RD: avm_adr_d = ADR_STATUS;
         default: ;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         state_q       <= S_IDLE;
         idx_q         <= '0;
         byte_q        <= '0;
         retry_q       <= '0;
         gap_q         <= GAP_LOAD;
         entry_q       <= '0;
         err_q         <= 1'b0;
         err_idx_q     <= '0;
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
         tbl_adr_q     <= '0;
         avm_adr_q     <= '0;
         avm_wr_q      <= 1'b0;
         avm_wr_data_q <= '0;
         avm_rd_q      <= 1'b0;
      end else begin
         state_q       <= state_d;
         idx_q         <= idx_d;
         byte_q        <= byte_d;
         retry_q       <= retry_d;
         gap_q         <= gap_d;
         entry_q       <= entry_d;
         err_q         <= err_d;
         err_idx_q     <= err_idx_d;
         busy_q        <= busy_d;
         done_q        <= done_d;
         tbl_adr_q     <= tbl_adr_d;
         avm_adr_q     <= avm_adr_d;
         avm_wr_q      <= avm_wr_d;
         avm_wr_data_q <= avm_wr_data_d;
         avm_rd_q      <= avm_rd_d;
      end
   end

   assign busy      = busy_q;
   assign done      = done_q;
   assign err       = err_q;
   assign errIdx    = err_idx_q;
   assign tblAdr    = tbl_adr_q;
   assign avmAdr    = avm_adr_q;
   assign avmWr     = avm_wr_q;
   assign avmWrData = avm_wr_data_q;
   assign avmRd     = avm_rd_q;

endmodule

// File: tb/tb_i2c_init_sequencer.sv
// Bench for i2c_init_sequencer: ROM and i2cMaster slave models, a transaction-level
// reference model of the expected Avalon write stream, and a minimum-timing instance.
module tb_i2c_init_sequencer;
   localparam int NUM     = 2;
   localparam int GAP     = 4;
   localparam int RETRIES = 2;
   localparam int TIMEOUT = 5000;

   logic        clk = 1'b0, resetN = 1'b0, start = 1'b0;
   logic        busy, done, err;
   logic [0:0]  errIdx, tblAdr;
   logic [23:0] tblData = '0;
   logic [1:0]  avmAdr;
   logic        avmWr, avmRd;
   logic [7:0]  avmWrData;
   logic [7:0]  avmRdData = '0;

   // Minimum-timing instance: one entry, one-cycle gap, slave always idle and acking.
   logic        start2 = 1'b0, busy2, done2, err2, avmWr2, avmRd2;
   logic [0:0]  errIdx2, tblAdr2;
   logic [1:0]  avmAdr2;
   logic [7:0]  avmWrData2;
   logic [23:0] tblData2   = 24'h1A2B3C;
   logic [7:0]  avmRdData2 = 8'h00;

   int n_checks = 0, n_fail = 0;

   logic [23:0] rom [NUM];
   bit          nack_plan [64];
   int          busy_polls = 0;

   always #5 clk = ~clk;

   i2c_init_sequencer #(.NUM_ENTRIES(NUM), .RETRIES(RETRIES), .POLL_GAP(GAP)) dut (
      .clk(clk), .resetN(resetN), .start(start), .busy(busy), .done(done), .err(err),
      .errIdx(errIdx), .tblAdr(tblAdr), .tblData(tblData), .avmAdr(avmAdr), .avmWr(avmWr),
      .avmWrData(avmWrData), .avmRd(avmRd), .avmRdData(avmRdData));

   i2c_init_sequencer #(.NUM_ENTRIES(1), .RETRIES(RETRIES), .POLL_GAP(1)) dut_min (
      .clk(clk), .resetN(resetN), .start(start2), .busy(busy2), .done(done2), .err(err2),
      .errIdx(errIdx2), .tblAdr(tblAdr2), .tblData(tblData2), .avmAdr(avmAdr2), .avmWr(avmWr2),
      .avmWrData(avmWrData2), .avmRd(avmRd2), .avmRdData(avmRdData2));

   // Synchronous ROM, one cycle read latency.
   always @(posedge clk) tblData <= rom[tblAdr];

   // i2cMaster model: each CMD write makes it report busy for busy_polls status reads;
   // the k-th write command of a run NACKs when nack_plan[k] is set.
   int polls_left = 0, wr_ord = 0;
   bit cur_nack = 1'b0, slv_busy_prev = 1'b0;
   always @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         polls_left    <= 0;
         wr_ord        <= 0;
         cur_nack      <= 1'b0;
         avmRdData     <= 8'h00;
         slv_busy_prev <= 1'b0;
      end else begin
         slv_busy_prev <= busy;
         if (busy && !slv_busy_prev) wr_ord <= 0;
         else if (avmWr && avmAdr == 2'd1 && avmWrData[2]) wr_ord <= wr_ord + 1;
         if (avmWr && avmAdr == 2'd1) begin
            polls_left <= busy_polls;
            cur_nack   <= avmWrData[2] && nack_plan[wr_ord];
         end
         if (avmRd && avmAdr == 2'd2) begin
            avmRdData <= {6'b0, cur_nack && (polls_left == 0), polls_left != 0};
            if (polls_left != 0) polls_left <= polls_left - 1;
         end
      end
   end

   // Bus monitor: write log, per-run busy length, fetched-index mask, strobe rules.
   typedef struct packed { logic [1:0] adr; logic [7:0] data; } wr_t;
   wr_t         wr_log [$];
   wr_t         exp_q [$];
   int          busy_cycles = 0, proto_err = 0;
   int unsigned adr_mask = 0;
   logic        mon_busy_prev = 1'b0, prev_wr = 1'b0, prev_rd = 1'b0;
   logic [1:0]  prev_adr = '0;
   always @(negedge clk) begin
      mon_busy_prev <= busy;
      if (busy && !mon_busy_prev) begin
         busy_cycles <= 1;
         adr_mask    <= 32'd1 << tblAdr;
      end else if (busy) begin
         busy_cycles <= busy_cycles + 1;
         adr_mask    <= adr_mask | (32'd1 << tblAdr);
      end
      if (avmWr) wr_log.push_back('{adr: avmAdr, data: avmWrData});
      if ((avmWr && avmRd) || ((avmWr || avmRd) && (prev_wr || prev_rd) && avmAdr == prev_adr))
         proto_err <= proto_err + 1;
      prev_wr  <= avmWr;
      prev_rd  <= avmRd;
      prev_adr <= avmAdr;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference model: walks entries/attempts/bytes and builds the expected write stream,
   // final error state, fetched entries and busy duration.
   bit exp_err;
   int exp_idx, exp_cycles;
   int unsigned exp_mask;
   task automatic model();
      int          ord;
      bit          ok;
      logic [23:0] w;
      int          poll_cost;
      ord = 0;
      poll_cost = (busy_polls + 1) * (GAP + 2);
      exp_q.delete();
      exp_err = 0; exp_idx = 0; exp_mask = 0; exp_cycles = 0;
      for (int n = 0; n < NUM; n++) begin
         exp_mask |= 32'd1 << n;
         exp_cycles += 2;
         ok = 0;
         for (int a = 0; a <= RETRIES && !ok; a++) begin
            ok = 1;
            for (int b = 0; b < 3 && ok; b++) begin
               w = rom[n] >> (8 * (2 - b));
               exp_q.push_back('{adr: 2'd0, data: w[7:0]});
               exp_q.push_back('{adr: 2'd1, data: {5'b0, 1'b1, b == 2, b == 0}});
               exp_cycles += 2 + poll_cost;
               if (nack_plan[ord]) begin
                  exp_q.push_back('{adr: 2'd1, data: 8'h02});
                  exp_cycles += 1 + poll_cost;
                  ok = 0;
               end
               ord++;
            end
         end
         if (!ok) begin
            exp_err = 1;
            exp_idx = n;
            break;
         end
         exp_cycles += 1;
      end
   endtask

   task automatic clear_plan();
      for (int k = 0; k < 64; k++) nack_plan[k] = 1'b0;
   endtask

   task automatic random_setup();
      for (int i = 0; i < NUM; i++) rom[i] = 24'($urandom) & 24'hFEFFFF;
      for (int k = 0; k < 64; k++) nack_plan[k] = ($urandom_range(0, 3) == 0);
      busy_polls = $urandom_range(0, 3);
   endtask

   task automatic do_run(input string tag, input bit mid_start, input bit start_at_done);
      int  base, bad;
      bit  got;
      wr_t ow, ew;
      model();
      base = wr_log.size();
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
      check({tag, ":busy_rise"}, busy, 1);
      check({tag, ":err_clr"}, err, 0);
      got = 0;
      for (int c = 0; c < TIMEOUT && !got; c++) begin
         @(negedge clk);
         start = mid_start && (c == 20);
         if (done) got = 1;
      end
      start = 1'b0;
      check({tag, ":done_seen"}, got, 1);
      check({tag, ":busy_at_done"}, busy, 0);
      check({tag, ":err"}, err, exp_err);
      check({tag, ":errIdx"}, errIdx, exp_idx);
      check({tag, ":fetched"}, adr_mask, exp_mask);
      check({tag, ":cycles"}, busy_cycles, exp_cycles);
      check({tag, ":wr_count"}, wr_log.size() - base, exp_q.size());
      bad = -1; ow = '0; ew = '0;
      for (int i = 0; i < exp_q.size(); i++) begin
         if (bad < 0 && (base + i >= wr_log.size() || wr_log[base + i] !== exp_q[i])) begin
            bad = i;
            ew  = exp_q[i];
            ow  = (base + i < wr_log.size()) ? wr_log[base + i] : '1;
         end
      end
      check({tag, ":wr_seq"}, ow, ew);
      if (start_at_done) start = 1'b1;
      @(negedge clk) start = 1'b0;
      check({tag, ":done_pulse"}, done, 0);
      @(negedge clk);
      check({tag, ":idle_after"}, busy, 0);
   endtask

   int  cyc, wr2;
   bit  got;

   initial begin
      clear_plan();
      rom[0] = 24'h341E00;
      rom[1] = 24'h340C10;
      busy_polls = 3;

      repeat (3) @(negedge clk);
      check("rst:busy", busy, 0);
      check("rst:done", done, 0);
      check("rst:err", err, 0);
      check("rst:avmWr", avmWr, 0);
      check("rst:avmRd", avmRd, 0);
      check("rst:outs", {errIdx, tblAdr, avmAdr, avmWrData}, 0);
      resetN = 1'b1;
      repeat (2) @(negedge clk);

      // Clean two-entry run with three busy polls per command.
      do_run("A", 0, 0);

      // NACK on byte 1 of entry 1 (write command #4), first attempt only.
      nack_plan[4] = 1'b1;
      do_run("B", 0, 0);

      // Entry 0 NACKs on every attempt: 3 attempts then err with entry 1 skipped.
      clear_plan();
      nack_plan[0] = 1'b1; nack_plan[1] = 1'b1; nack_plan[2] = 1'b1;
      do_run("C", 0, 0);

      // Fresh start clears err; mid-run and done-cycle start pulses are ignored.
      clear_plan();
      rom[0] = 24'hA05511;
      rom[1] = 24'h30F0C3;
      busy_polls = 1;
      do_run("D", 1, 1);

      // Asynchronous reset during the status gap of entry 1.
      busy_polls = 0;
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
      got = 0;
      for (int c = 0; c < TIMEOUT && !got; c++) begin
         @(negedge clk);
         if (avmWr && avmAdr == 2'd1 && tblAdr == 1'b1) got = 1;
      end
      check("rst_mid:reach_entry1", got, 1);
      repeat (2) @(negedge clk);
      #1 resetN = 1'b0;
      #1;
      check("rst_mid:busy", busy, 0);
      check("rst_mid:tblAdr", tblAdr, 0);
      check("rst_mid:outs", {done, err, errIdx, avmAdr, avmWr, avmRd, avmWrData}, 0);
      @(negedge clk) resetN = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_mid:stays_idle", busy, 0);
      do_run("E", 0, 0);

      for (int r = 0; r < 6; r++) begin
         random_setup();
         do_run($sformatf("R%0d", r), 0, 0);
      end

      // Back-to-back minimum timing: 2 + 3*(4+1) + 1 busy cycles, 6 writes.
      @(negedge clk) start2 = 1'b1;
      @(negedge clk) start2 = 1'b0;
      cyc = 0; wr2 = 0; got = 0;
      for (int c = 0; c < TIMEOUT && !got; c++) begin
         if (done2) got = 1;
         else begin
            if (busy2) cyc++;
            if (avmWr2) wr2++;
            @(negedge clk);
         end
      end
      check("min:done_seen", got, 1);
      check("min:cycles", cyc, 2 + 3 * (4 + 1) + 1);
      check("min:writes", wr2, 6);
      check("min:err", err2, 0);
      check("min:busy_at_done", busy2, 0);

      check("bus:strobe_rules", proto_err, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
